// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash/SRAM responder.
package spi_flash_responder_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    SPIR_IDLE   = 3'd0,
    SPIR_CMD    = 3'd1,
    SPIR_ADDR   = 3'd2,
    SPIR_READ   = 3'd3,
    SPIR_WRITE  = 3'd4,
    SPIR_STATUS = 3'd5,
    SPIR_IGNORE = 3'd6
  } spir_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer chains for cs/sclk/mosi plus rise/fall detection on sclk and cs.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
  end

  // cs resets to its idle (deasserted) level so no false edge appears after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
  assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
  assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a serial flash/SRAM over an attached byte memory
// (READ 0x03, WRITE 0x02, RDSR 0x05, 24-bit address truncated to ADDR_W).
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  STATUS_VAL  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              cmd_err
);

  logic cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .cs        (spi_cs),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .cs_s      (cs_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  spir_state_e       state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic [7:0]        tx_buf_q, tx_buf_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cmd_err_q, cmd_err_d;
  logic              oe_q, oe_d;
  logic              op_wr_q, op_wr_d;
  logic              latch_q, latch_d;
  logic              inc_q, inc_d;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_one;

  assign byte_in    = {rx_q, mosi_s};
  assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
  assign addr_one   = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    tx_sh_d     = tx_sh_q;
    tx_buf_d    = tx_buf_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cmd_err_d   = 1'b0;
    oe_d        = oe_q;
    op_wr_d     = op_wr_q;
    latch_d     = 1'b0;
    inc_d       = 1'b0;

    // Deferred memory-side actions from the previous clk
    if (latch_q) tx_buf_d = mem_rdata;
    if (inc_q)   mem_addr_d = mem_addr_q + addr_one;

    if (cs_rise) begin
      state_d   = SPIR_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (state_q == SPIR_IDLE) begin
      if (cs_fall) begin
        state_d   = SPIR_CMD;
        bit_cnt_d = '0;
      end
    end else if (!cs_s && sclk_rise) begin
      rx_d      = byte_in[6:0];
      bit_cnt_d = bit_cnt_q + 5'd1;
      case (state_q)
        SPIR_CMD: begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            case (byte_in)
              SPI_CMD_READ:  begin state_d = SPIR_ADDR;   op_wr_d = 1'b0; end
              SPI_CMD_WRITE: begin state_d = SPIR_ADDR;   op_wr_d = 1'b1; end
              SPI_CMD_RDSR:  state_d = SPIR_STATUS;
              default: begin
                state_d   = SPIR_IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
        SPIR_ADDR: begin
          addr_d = addr_shift;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d  = '0;
            mem_addr_d = addr_shift;
            if (op_wr_q) begin
              state_d = SPIR_WRITE;
            end else begin
              state_d = SPIR_READ;
              latch_d = 1'b1;
            end
          end
        end
        SPIR_READ: begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d  = '0;
            mem_addr_d = mem_addr_q + addr_one;
            latch_d    = 1'b1;
          end
        end
        SPIR_WRITE: begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d   = '0;
            mem_wdata_d = byte_in;
            mem_we_d    = 1'b1;
            inc_d       = 1'b1;
          end
        end
        SPIR_STATUS: begin
          if (bit_cnt_q == 5'd7) bit_cnt_d = '0;
        end
        default: bit_cnt_d = '0;
      endcase
    end else if (!cs_s && sclk_fall &&
                 (state_q == SPIR_READ || state_q == SPIR_STATUS)) begin
      // A fall with no bits counted is a byte boundary: reload instead of shifting
      oe_d = 1'b1;
      if (bit_cnt_q == 5'd0)
        tx_sh_d = (state_q == SPIR_READ) ? tx_buf_q : STATUS_VAL;
      else
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SPIR_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      tx_sh_q     <= '0;
      tx_buf_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      oe_q        <= 1'b0;
      op_wr_q     <= 1'b0;
      latch_q     <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      tx_sh_q     <= tx_sh_d;
      tx_buf_q    <= tx_buf_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cmd_err_q   <= cmd_err_d;
      oe_q        <= oe_d;
      op_wr_q     <= op_wr_d;
      latch_q     <= latch_d;
      inc_q       <= inc_d;
    end
  end

  assign spi_miso    = oe_q & tx_sh_q[7];
  assign spi_miso_oe = oe_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign cmd_err     = cmd_err_q;
  assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: read, wrap, write, abort, bad/status opcodes, reset.
module tb_spi_flash_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata, mem_wdata;
  logic       mem_we, busy, cmd_err;

  logic [7:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         we_cnt = 0;
  int         we_run = 0;
  int         we_max = 0;
  int         err_cnt = 0;
  logic [9:0] we_a [$];
  logic [7:0] we_d [$];

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt = we_cnt + 1;
      we_a.push_back(mem_addr);
      we_d.push_back(mem_wdata);
      we_run = we_run + 1;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
    if (cmd_err) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx (MSB first); capture MISO and OE at each sclk rise
  task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      #40;
      spi_sclk = 1'b1;
      rx[7-i] = spi_miso;
      oe[7-i] = spi_miso_oe;
      #40;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #40;
    spi_cs = 1'b1;
    #80;
  endtask

  logic [7:0] rx, oe;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h010] = 8'hA5;
    mem[10'h011] = 8'h3C;
    mem[10'h3FF] = 8'hE7;
    mem[10'h000] = 8'h81;
    mem[10'h030] = 8'h69;
    mem[10'h050] = 8'h11;
    mem[10'h051] = 8'h22;

    // Reset state
    #33;
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    #50;

    // 1. Basic read from 0x000010
    cs_low();
    chk("t1_busy", 32'(busy), 32'd1);
    spi_xfer(8'h03, 8, rx, oe); chk("t1_cmd_oe", 32'(oe), 32'h00);
    spi_xfer(8'h00, 8, rx, oe); chk("t1_a2_oe", 32'(oe), 32'h00);
    spi_xfer(8'h00, 8, rx, oe); chk("t1_a1_oe", 32'(oe), 32'h00);
    spi_xfer(8'h10, 8, rx, oe); chk("t1_a0_oe", 32'(oe), 32'h00);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t1_d0", 32'(rx), 32'hA5);
    chk("t1_d0_oe", 32'(oe), 32'hFF);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t1_d1", 32'(rx), 32'h3C);
    chk("t1_d1_oe", 32'(oe), 32'hFF);
    cs_high();
    chk("t1_addr", 32'(mem_addr), 32'h012);
    chk("t1_oe_off", 32'(spi_miso_oe), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);

    // 2. Read wrapping past the top of the 10-bit space
    cs_low();
    spi_xfer(8'h03, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h03, 8, rx, oe);
    spi_xfer(8'hFF, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t2_d0", 32'(rx), 32'hE7);
    chk("t2_wrap_addr", 32'(mem_addr), 32'h000);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t2_d1", 32'(rx), 32'h81);
    cs_high();
    chk("t2_addr", 32'(mem_addr), 32'h001);

    // 3. Two-byte write at 0x000020
    we_cnt = 0; we_max = 0; we_a.delete(); we_d.delete();
    cs_low();
    spi_xfer(8'h02, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h20, 8, rx, oe);
    spi_xfer(8'h5A, 8, rx, oe);
    chk("t3_wr_oe", 32'(oe), 32'h00);
    spi_xfer(8'hC3, 8, rx, oe);
    cs_high();
    #200;
    chk("t3_we_cnt", 32'(we_cnt), 32'd2);
    chk("t3_we_width", 32'(we_max), 32'd1);
    chk("t3_a0", 32'(we_a[0]), 32'h020);
    chk("t3_d0", 32'(we_d[0]), 32'h5A);
    chk("t3_a1", 32'(we_a[1]), 32'h021);
    chk("t3_d1", 32'(we_d[1]), 32'hC3);
    chk("t3_addr", 32'(mem_addr), 32'h022);

    // 4. Write aborted after 5 data bits, then a read
    we_cnt = 0;
    cs_low();
    spi_xfer(8'h02, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h30, 8, rx, oe);
    spi_xfer(8'hFF, 5, rx, oe);
    cs_high();
    #200;
    chk("t4_no_we", 32'(we_cnt), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_addr_hold", 32'(mem_addr), 32'h030);
    cs_low();
    spi_xfer(8'h03, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h30, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t4_read", 32'(rx), 32'h69);
    cs_high();

    // 5. Unsupported opcode, then RDSR
    err_cnt = 0;
    cs_low();
    spi_xfer(8'h9F, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe); chk("t5_ign_oe0", 32'(oe), 32'h00);
    spi_xfer(8'h00, 8, rx, oe); chk("t5_ign_oe1", 32'(oe), 32'h00);
    cs_high();
    chk("t5_err_cnt", 32'(err_cnt), 32'd1);
    cs_low();
    spi_xfer(8'h05, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t5_sr0", 32'(rx), 32'h00);
    chk("t5_sr0_oe", 32'(oe), 32'hFF);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t5_sr1", 32'(rx), 32'h00);
    chk("t5_sr1_oe", 32'(oe), 32'hFF);
    cs_high();
    chk("t5_err_total", 32'(err_cnt), 32'd1);

    // 6. Reset in the middle of the second read byte
    cs_low();
    spi_xfer(8'h03, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h50, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t6_d0", 32'(rx), 32'h11);
    spi_xfer(8'h00, 3, rx, oe);
    #13;
    rst = 1'b1;
    #1;
    chk("t6_rst_miso", 32'(spi_miso), 32'd0);
    chk("t6_rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("t6_rst_we", 32'(mem_we), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_addr", 32'(mem_addr), 32'd0);
    spi_cs = 1'b1;
    #30;
    rst = 1'b0;
    #100;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    cs_low();
    spi_xfer(8'h03, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    spi_xfer(8'h50, 8, rx, oe);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t6_re_d0", 32'(rx), 32'h11);
    spi_xfer(8'h00, 8, rx, oe);
    chk("t6_re_d1", 32'(rx), 32'h22);
    cs_high();
    chk("t6_re_addr", 32'(mem_addr), 32'h052);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Synthesizable SPI responder (target side) for the SPI program-memory link of the CPU. It emulates a serial flash/SRAM: it decodes opcode + 24-bit address from the master and streams bytes from an attached byte memory, or writes bytes into it. It is used as a loop-back/emulation target on spare uio pins and as the on-chip flash model in system benches. SPI mode 0, MSB first, single-bit I/O.

Parameters:
ADDR_W, 10, width of the memory address bus; the 24-bit SPI address is truncated to ADDR_W bits and wraps modulo 2^ADDR_W.
SYNC_STAGES, 2, number of synchronizer flops on spi_cs, spi_sclk and spi_mosi (minimum 2).
STATUS_VAL, 8'h00, byte returned repeatedly by the RDSR command.

Ports:
clk  in  1  system clock; must run at least 4x spi_sclk.
rst  in  1  asynchronous reset, active-high.
spi_cs  in  1  chip select, active-low.
spi_sclk  in  1  SPI clock from the master.
spi_mosi  in  1  master-to-responder data.
spi_miso  out  1  responder-to-master data.
spi_miso_oe  out  1  MISO output enable; high only while returning data.
mem_addr  out  ADDR_W  byte address to the attached memory.
mem_rdata  in  8  read data; valid 1 clk after mem_addr changes.
mem_wdata  out  8  write data.
mem_we  out  1  one-clk write strobe.
busy  out  1  high while spi_cs is low (synchronized).
cmd_err  out  1  one-clk pulse on an unsupported opcode.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the shift and bit counters are cleared.
- Inputs pass through SYNC_STAGES flops. Sclk rise and fall events are derived from the last two synchronized samples. All actions occur on the clk after a detected event.
- MOSI is sampled on sclk rise. MISO is updated on sclk fall.
- States: IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE.
- IDLE -> CMD when synchronized cs falls; the bit counter clears.
- CMD: shift 8 bits, then decode the opcode.
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (write).
  - 0x05 -> STATUS.
  - Any other opcode -> IGNORE and pulse cmd_err.
- ADDR: shift 24 bits. On the 24th rise, mem_addr <= addr[ADDR_W-1:0].
  - Read: the next clk latches mem_rdata into the tx buffer, then go to READ.
  - Write: go to WRITE.
- READ:
  - On each sclk fall at a byte boundary, load the shift register from the tx buffer.
  - On other falls, shift left. spi_miso = shreg[7] and spi_miso_oe = 1.
  - On the 8th rise of each byte, mem_addr increments (wrapping 2^ADDR_W-1 -> 0). The next clk relatches the tx buffer.
  - This continues indefinitely while cs is low.
- WRITE: collect 8 MOSI bits. On the 8th rise, mem_wdata = byte and mem_we pulses for exactly 1 clk. mem_addr increments on the following clk.
- STATUS: stream STATUS_VAL repeatedly, with the same timing as READ.
- IGNORE: MISO undriven (oe = 0); wait for cs to rise.
- Chip-select deassert: synchronized cs rising in any state forces IDLE on the next clk.
  - oe and spi_miso go to 0.
  - A partial write byte is discarded (no mem_we).
  - A partial command or address is discarded.
  - mem_addr holds its value.
- busy = synchronized ~cs.
- Async rst mid-transfer returns everything to reset values immediately. A transfer then resumes only after a fresh cs fall.
- A sclk edge seen while cs is high is ignored.
- Simultaneous cs-rise and sclk-edge in the same clk: cs-rise wins.

Decomposition:
- defines.vh holds:
  - opcodes SPI_CMD_READ 8'h03, SPI_CMD_WRITE 8'h02, SPI_CMD_RDSR 8'h05;
  - the state encodings SPIR_IDLE..SPIR_IGNORE (3 bits).
- One sub-module, spi_pin_sync: parameterized synchronizer chain plus rise/fall edge detector for sclk and cs. It is reused by any future SPI-facing block.

Test Plan:
1. Read: cs low, send 0x03 then address 0x000010, clock 16 bits, with memory[0x10]=0xA5 and [0x11]=0x3C -> MISO returns 0xA5, 0x3C MSB first; mem_addr ends at 0x012; oe high only during data bits.
2. Wrap: read from address 0x0003FF (ADDR_W=10) for 2 bytes -> bytes [0x3FF] then [0x000]; mem_addr wraps to 0x000.
3. Write: 0x02, address 0x000020, data 0x5A, 0xC3 -> two mem_we pulses of 1 clk each: (0x020, 0x5A) and (0x021, 0xC3); no extra pulse after cs rises.
4. Abort: 0x02, address, then 5 data bits, cs high -> no mem_we; state IDLE; busy falls; the next 0x03 transaction reads correctly.
5. Bad and status commands: opcode 0x9F -> single cmd_err pulse and oe stays 0 for 16 further clocks. Opcode 0x05 -> MISO returns 0x00, 0x00.
6. Reset mid-read: assert rst during byte 2 of a read -> spi_miso, oe, mem_we, busy and mem_addr all 0 in the same cycle; after release, a new cs cycle reads correctly.
